fm_spy_buf: RTL and testbench
=============================

FM_SPY_BUF -- requirements
Module: fm_spy_buf

Interface
REQ-001 The module SHALL have parameter N_CH, default 4, meaning the number of spied channels sharing one capture controller.
REQ-002 The module SHALL have parameter DATA_W, default 64, meaning the data width per channel.
REQ-003 The module SHALL have parameter DEPTH, default 1024 (power of 2, ≥4), meaning the entries per channel; AW = $clog2(DEPTH).
REQ-004 Ports, with clock and reset listed first:
- clk_hs in 1: the single clock.
- rst_hs in 1: reset, synchronous, active-high.
- in_data in N_CH×DATA_W: live data.
- in_valid in N_CH: live valid.
- arm in 1: pulse, start recording.
- trig in 1: pulse, trigger.
- force_freeze in 1: pulse, immediate freeze.
- post_cnt in AW: post-trigger samples.
- pb_mode in 2: 0 off, 1 one-shot, 2 loop, 3 reserved (treated as 0).
- pb_start in 1: pulse, start playback.
- pb_stop in 1: pulse, stop playback.
- rd_en in 1: readout request.
- rd_ch in $clog2(N_CH): readout channel.
- rd_addr in AW: readout address.
- rd_data out DATA_W+1: {valid, data}.
- rd_valid out 1: readout data is present.
- out_data out N_CH×DATA_W: live data or playback data.
- out_valid out N_CH: output valid.
- state out 3: FSM state.
- trig_ptr out AW: write address at trigger.
- wr_ptr out AW: next write address.
- wrapped out 1: buffer has filled at least once.

Function
REQ-005 FSM states SHALL be IDLE=0, ARMED=1, POST=2, FROZEN=3, PLAY=4.
REQ-006 In ARMED and POST, every cycle SHALL write {in_valid[c], in_data[c]} for every c at wr_ptr and increment wr_ptr modulo DEPTH; wrapping SHALL set wrapped.
REQ-007 arm in IDLE or FROZEN SHALL enter ARMED next cycle with wr_ptr=0 and wrapped=0; arm in any other state SHALL be ignored.
REQ-008 trig in ARMED SHALL latch trig_ptr=wr_ptr (the trigger-cycle sample is stored) and enter POST with counter=min(post_cnt, DEPTH-1).
REQ-009 POST SHALL decrement the counter per written sample and enter FROZEN after the cycle in which the counter is 0; post_cnt=0 SHALL freeze the cycle after the trigger write.
REQ-010 trig outside ARMED SHALL be ignored.
REQ-011 force_freeze in ARMED or POST SHALL enter FROZEN next cycle; it SHALL take priority over a simultaneous trig, and the write in that cycle SHALL still occur.
REQ-012 No writes SHALL occur in IDLE, FROZEN or PLAY.
REQ-013 Readout SHALL have a fixed 1-cycle latency: rd_valid=1 and rd_data=mem[rd_ch][rd_addr] one cycle after rd_en, in any state. In ARMED/POST the value read-before-write is undefined and no error is flagged.
REQ-014 pb_start in FROZEN with pb_mode 1 or 2 SHALL enter PLAY; pb_start is ignored otherwise.
REQ-015 Playback start address SHALL be wr_ptr if wrapped=1, else 0; playback SHALL emit one entry per cycle per channel on out_data/out_valid (out_valid = stored valid bit), 2-cycle latency from pb_start to the first entry.
REQ-016 One-shot playback SHALL return to FROZEN after emitting the entry at wr_ptr-1. If wrapped=0 and wr_ptr=0, it SHALL return immediately with nothing emitted.
REQ-017 Loop playback SHALL restart at the start address after the last entry, without a gap.
REQ-018 pb_stop in PLAY SHALL enter FROZEN next cycle.
REQ-019 Outside PLAY, out_data/out_valid SHALL equal in_data/in_valid registered one cycle.
REQ-020 Readout during PLAY SHALL be arbitrated so that playback is never stalled; each channel's memory uses one write/playback port and one readout port.

Reset
REQ-021 rst_hs=1 at a clock edge SHALL set the following, from any state including mid-POST or mid-PLAY: state=IDLE, wr_ptr=0, trig_ptr=0, wrapped=0, counter=0, rd_valid=0, rd_data=0, out_valid=0, out_data=0.
REQ-022 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-023 The state enum, the pb_mode encodings and the default parameters SHALL live in fm_sb_pkg.
REQ-024 Per-channel storage SHALL be sub-module fm_spy_ram: simple dual-port, registered read, DEPTH×(DATA_W+1).
REQ-025 The FSM and pointers SHALL be shared by all channels.

Verification
REQ-026 Scenario 1: DEPTH=16, arm, then a counter pattern 0..39, trig at sample 20, post_cnt=3 -> FROZEN after sample 23, trig_ptr=4, wr_ptr=8, wrapped=1.
REQ-027 Scenario 2: no wrap (trig at sample 5, post_cnt=0), then one-shot playback -> samples 0..5 emitted in order, then state=FROZEN.
REQ-028 Scenario 3: force_freeze and trig in the same ARMED cycle -> FROZEN, trig_ptr unchanged, that sample stored.
REQ-029 Scenario 4: loop playback of a wrapped 16-entry buffer for 40 cycles, then pb_stop -> continuous sequence from the oldest entry, FROZEN next cycle.
REQ-030 Scenario 5: rst_hs during POST -> all outputs at reset values next cycle; a subsequent readout returns the previously written data.
REQ-031 Scenario 6: readout rd_ch=N_CH-1, rd_addr=trig_ptr while FROZEN -> trigger sample with its valid bit, 1 cycle later.

Source files
------------

// File: rtl/fm_sb_pkg.sv
// Shared types and defaults for the spy buffer: FSM state encoding,
// playback mode encoding and default geometry.
package fm_sb_pkg;

    localparam int unsigned N_CH_DEF   = 4;
    localparam int unsigned DATA_W_DEF = 64;
    localparam int unsigned DEPTH_DEF  = 1024;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_POST   = 3'd2,
        ST_FROZEN = 3'd3,
        ST_PLAY   = 3'd4
    } sb_state_e;

    typedef enum logic [1:0] {
        PB_OFF     = 2'd0,
        PB_ONESHOT = 2'd1,
        PB_LOOP    = 2'd2,
        PB_RSVD    = 2'd3
    } pb_mode_e;

    // The reserved encoding behaves like "off".
    function automatic logic pb_mode_active(input logic [1:0] mode);
        return (mode == PB_ONESHOT) || (mode == PB_LOOP);
    endfunction

endpackage

// File: rtl/fm_spy_ram.sv
// Per-channel capture store: port A writes during capture and reads for
// playback, port B serves readout. Both reads are registered.
module fm_spy_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 65,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk_hs,
    input  logic             i_a_we,
    input  logic [AW-1:0]    i_a_addr,
    input  logic [WIDTH-1:0] i_a_wdata,
    output logic [WIDTH-1:0] o_a_rdata,
    input  logic             i_b_en,
    input  logic [AW-1:0]    i_b_addr,
    output logic [WIDTH-1:0] o_b_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_a_rdata;
    logic [WIDTH-1:0] r_b_rdata;

    // NOTE: the array has no reset so it maps onto block RAM; captured data
    // deliberately survives a controller reset.
    always_ff @(posedge clk_hs) begin
        if (i_a_we) begin
            r_mem[i_a_addr] <= i_a_wdata;
        end
        r_a_rdata <= r_mem[i_a_addr];
        if (i_b_en) begin
            r_b_rdata <= r_mem[i_b_addr];
        end
    end

    assign o_a_rdata = r_a_rdata;
    assign o_b_rdata = r_b_rdata;

endmodule

// File: rtl/fm_spy_buf.sv
// Multi-channel spy buffer: one shared capture/playback controller driving
// a private RAM per channel, with an independent readout port.
module fm_spy_buf
    import fm_sb_pkg::*;
#(
    parameter int unsigned N_CH   = N_CH_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk_hs,
    input  logic                     rst_hs,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    input  logic [N_CH-1:0]          in_valid,
    input  logic                     arm,
    input  logic                     trig,
    input  logic                     force_freeze,
    input  logic [AW-1:0]            post_cnt,
    input  logic [1:0]               pb_mode,
    input  logic                     pb_start,
    input  logic                     pb_stop,
    input  logic                     rd_en,
    input  logic [CW-1:0]            rd_ch,
    input  logic [AW-1:0]            rd_addr,
    output logic [DATA_W:0]          rd_data,
    output logic                     rd_valid,
    output logic [N_CH*DATA_W-1:0]   out_data,
    output logic [N_CH-1:0]          out_valid,
    output logic [2:0]               state,
    output logic [AW-1:0]            trig_ptr,
    output logic [AW-1:0]            wr_ptr,
    output logic                     wrapped
);

    sb_state_e        r_state, w_state_nxt;
    logic [AW-1:0]    r_wr_ptr, r_trig_ptr, r_cnt, r_pb_addr;
    logic             r_wrapped, r_pb_done, r_pb_loop, r_emit;
    logic             r_rd_valid;
    logic [CW-1:0]    r_rd_ch;
    logic [N_CH*DATA_W-1:0] r_live_data;
    logic [N_CH-1:0]  r_live_valid;
    logic [DATA_W:0]  w_pb_word [N_CH];
    logic [DATA_W:0]  w_rd_word [N_CH];

    logic          w_capture, w_arm_ok, w_pb_enter, w_pb_issue;
    logic [AW-1:0] w_last_addr, w_pb_first, w_ram_addr;

    assign w_capture   = (r_state == ST_ARMED) || (r_state == ST_POST);
    assign w_arm_ok    = arm && ((r_state == ST_IDLE) || (r_state == ST_FROZEN));
    assign w_pb_enter  = (r_state == ST_FROZEN) && (w_state_nxt == ST_PLAY);
    assign w_pb_issue  = (r_state == ST_PLAY) && !r_pb_done;
    // Oldest entry first; the newest always sits just below the write pointer.
    assign w_last_addr = r_wr_ptr - AW'(1);
    assign w_pb_first  = r_wrapped ? r_wr_ptr : '0;
    assign w_ram_addr  = (r_state == ST_PLAY) ? r_pb_addr : r_wr_ptr;

    // NOTE: next state defaults to the current state so no path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (arm) w_state_nxt = ST_ARMED;
            ST_ARMED: begin
                if (force_freeze)       w_state_nxt = ST_FROZEN;
                else if (trig)          w_state_nxt = (post_cnt == '0) ? ST_FROZEN : ST_POST;
            end
            ST_POST:   if (force_freeze || (r_cnt <= AW'(1))) w_state_nxt = ST_FROZEN;
            ST_FROZEN: begin
                if (arm)                                  w_state_nxt = ST_ARMED;
                else if (pb_start && pb_mode_active(pb_mode)) w_state_nxt = ST_PLAY;
            end
            ST_PLAY:   if (pb_stop || r_pb_done) w_state_nxt = ST_FROZEN;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_hs) begin
        if (rst_hs) begin
            r_state    <= ST_IDLE;
            r_wr_ptr   <= '0;
            r_trig_ptr <= '0;
            r_wrapped  <= 1'b0;
            r_cnt      <= '0;
            r_pb_addr  <= '0;
            r_pb_done  <= 1'b0;
            r_pb_loop  <= 1'b0;
            r_emit     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                if (&r_wr_ptr) r_wrapped <= 1'b1;
            end
            if (w_arm_ok) begin
                r_wr_ptr  <= '0;
                r_wrapped <= 1'b0;
            end
            // post_cnt is AW bits wide, so it can never exceed DEPTH-1.
            if ((r_state == ST_ARMED) && trig && !force_freeze) begin
                r_trig_ptr <= r_wr_ptr;
                r_cnt      <= post_cnt;
            end else if ((r_state == ST_POST) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - AW'(1);
            end
            if (w_pb_enter) begin
                r_pb_addr <= w_pb_first;
                r_pb_done <= !r_wrapped && (r_wr_ptr == '0);
                r_pb_loop <= (pb_mode == PB_LOOP);
            end else if (w_pb_issue) begin
                if (r_pb_addr == w_last_addr) begin
                    if (r_pb_loop) r_pb_addr <= w_pb_first;
                    else           r_pb_done <= 1'b1;
                end else begin
                    r_pb_addr <= r_pb_addr + AW'(1);
                end
            end
            r_emit <= w_pb_issue;
        end
    end

    always_ff @(posedge clk_hs) begin
        if (rst_hs) begin
            r_rd_valid   <= 1'b0;
            r_rd_ch      <= '0;
            r_live_data  <= '0;
            r_live_valid <= '0;
        end else begin
            r_rd_valid   <= rd_en;
            if (rd_en) r_rd_ch <= rd_ch;
            r_live_data  <= in_data;
            r_live_valid <= in_valid;
        end
    end

    // Readout owns port B outright, so playback on port A never waits for it.
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        fm_spy_ram #(.DEPTH(DEPTH), .WIDTH(DATA_W + 1)) u_ram (
            .clk_hs    (clk_hs),
            .i_a_we    (w_capture && !rst_hs),
            .i_a_addr  (w_ram_addr),
            .i_a_wdata ({in_valid[g], in_data[g*DATA_W +: DATA_W]}),
            .o_a_rdata (w_pb_word[g]),
            .i_b_en    (rd_en),
            .i_b_addr  (rd_addr),
            .o_b_rdata (w_rd_word[g])
        );
    end

    always_comb begin
        rd_data   = r_rd_valid ? w_rd_word[r_rd_ch] : '0;
        out_data  = r_live_data;
        out_valid = r_live_valid;
        if ((r_state == ST_PLAY) && r_emit) begin
            for (int c = 0; c < N_CH; c++) begin
                out_data[c*DATA_W +: DATA_W] = w_pb_word[c][DATA_W-1:0];
                out_valid[c]                 = w_pb_word[c][DATA_W];
            end
        end
    end

    assign rd_valid = r_rd_valid;
    assign state    = r_state;
    assign trig_ptr = r_trig_ptr;
    assign wr_ptr   = r_wr_ptr;
    assign wrapped  = r_wrapped;

endmodule

// File: tb/tb_fm_spy_buf.sv
// Bench for fm_spy_buf: table-driven capture scenarios, loop playback,
// reset mid-capture and randomized captures against a history-based model.
module tb_fm_spy_buf;

    localparam int N_CH   = 4;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int OW     = N_CH * (DATA_W + 1);

    logic                   clk_hs = 1'b0;
    logic                   rst_hs = 1'b1;
    logic [N_CH*DATA_W-1:0] in_data = '0;
    logic [N_CH-1:0]        in_valid = '0;
    logic                   arm = 1'b0, trig = 1'b0, force_freeze = 1'b0;
    logic [AW-1:0]          post_cnt = '0;
    logic [1:0]             pb_mode = 2'd0;
    logic                   pb_start = 1'b0, pb_stop = 1'b0, rd_en = 1'b0;
    logic [1:0]             rd_ch = '0;
    logic [AW-1:0]          rd_addr = '0;
    logic [DATA_W:0]        rd_data;
    logic                   rd_valid;
    logic [N_CH*DATA_W-1:0] out_data;
    logic [N_CH-1:0]        out_valid;
    logic [2:0]             state;
    logic [AW-1:0]          trig_ptr, wr_ptr;
    logic                   wrapped;

    fm_spy_buf #(.N_CH(N_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk_hs(clk_hs), .rst_hs(rst_hs), .in_data(in_data), .in_valid(in_valid),
        .arm(arm), .trig(trig), .force_freeze(force_freeze), .post_cnt(post_cnt),
        .pb_mode(pb_mode), .pb_start(pb_start), .pb_stop(pb_stop), .rd_en(rd_en),
        .rd_ch(rd_ch), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .out_data(out_data), .out_valid(out_valid), .state(state),
        .trig_ptr(trig_ptr), .wr_ptr(wr_ptr), .wrapped(wrapped)
    );

    always #5 clk_hs = ~clk_hs;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: every sample ever offered, plus the memory image it implies.
    logic [DATA_W:0] hist [64][N_CH];
    logic [DATA_W:0] mm   [N_CH][DEPTH];
    int              m_tp = 0;

    typedef struct {
        int trig_at;
        int post;
        int force_at;
        int exp_tp;
        int exp_wp;
        bit exp_wrap;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_hs);
        #1;
    endtask

    function automatic logic [OW-1:0] exp_word(input int k);
        logic [N_CH-1:0]        v;
        logic [N_CH*DATA_W-1:0] d;
        for (int c = 0; c < N_CH; c++) begin
            v[c]                     = hist[k][c][DATA_W];
            d[c*DATA_W +: DATA_W]    = hist[k][c][DATA_W-1:0];
        end
        return {v, d};
    endfunction

    task automatic drive_sample(input int k, input bit rnd);
        logic [DATA_W-1:0] d;
        logic              v;
        for (int c = 0; c < N_CH; c++) begin
            if (rnd) begin
                d = DATA_W'($urandom);
                v = 1'($urandom);
            end else begin
                d = DATA_W'(c * 4096 + k);
                v = ((k + c) % 3) != 0;
            end
            hist[k][c]                    = {v, d};
            in_data[c*DATA_W +: DATA_W]   = d;
            in_valid[c]                   = v;
        end
    endtask

    task automatic do_reset;
        rst_hs = 1'b1;
        tick();
        rst_hs = 1'b0;
        m_tp   = 0;
    endtask

    // Model rule: the trigger sample plus post samples are kept unless a
    // force-freeze arrives first; that sample is still stored.
    task automatic capture(input int trig_at, input int post, input int force_at,
                           input int cycles, input bit rnd, output int n);
        int  n_trig;
        n_trig = trig_at + 1 + post;
        n      = (force_at >= 0 && force_at < n_trig) ? force_at + 1 : n_trig;
        if (!(force_at >= 0 && force_at <= trig_at)) m_tp = trig_at % DEPTH;
        post_cnt = AW'(post);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            drive_sample(k, rnd);
            trig         = (k == trig_at);
            force_freeze = (k == force_at);
            tick();
        end
        trig = 1'b0;
        force_freeze = 1'b0;
        for (int k = 0; k < n; k++)
            for (int c = 0; c < N_CH; c++)
                mm[c][k % DEPTH] = hist[k][c];
    endtask

    task automatic read_check(input int ch, input int addr, input string name);
        rd_en   = 1'b1;
        rd_ch   = 2'(ch);
        rd_addr = AW'(addr);
        tick();
        rd_en = 1'b0;
        check(name, 128'({rd_valid, rd_data}), 128'({1'b1, mm[ch][addr]}));
    endtask

    task automatic oneshot_check(input int n, input string name);
        int len, first;
        len   = (n >= DEPTH) ? DEPTH : n;
        first = n - len;
        pb_mode  = 2'd1;
        pb_start = 1'b1;
        tick();
        pb_start = 1'b0;
        tick();
        check({name, "_play_state"}, 128'(state), 128'(4));
        for (int i = 0; i < len; i++) begin
            check({name, "_entry"}, 128'({out_valid, out_data}), 128'(exp_word(first + i)));
            tick();
        end
        check({name, "_end_state"}, 128'(state), 128'(3));
    endtask

    initial begin
        int n;
        vecs[0] = '{20, 3, -1,  4,  8, 1'b1};
        vecs[1] = '{ 5, 0, -1,  5,  6, 1'b0};
        vecs[2] = '{ 2, 15, -1, 2,  2, 1'b1};
        vecs[3] = '{14, 1, -1, 14,  0, 1'b1};
        vecs[4] = '{ 3, 2,  3,  0,  4, 1'b0};
        vecs[5] = '{ 4, 10, 7,  4,  8, 1'b0};
        vecs[6] = '{30, 0,  9,  0, 10, 1'b0};

        do_reset();
        check("rst_state",   128'(state),    128'(0));
        check("rst_wr_ptr",  128'(wr_ptr),   128'(0));
        check("rst_wrapped", 128'(wrapped),  128'(0));
        check("rst_out",     128'({out_valid, out_data}), 128'(0));
        trig = 1'b1;
        tick();
        trig = 1'b0;
        check("trig_in_idle", 128'(state), 128'(0));

        for (int r = 0; r < 7; r++) begin
            do_reset();
            capture(vecs[r].trig_at, vecs[r].post, vecs[r].force_at, 40, 1'b0, n);
            check("tbl_state",   128'(state),    128'(3));
            check("tbl_trig_ptr", 128'(trig_ptr), 128'(vecs[r].exp_tp));
            check("tbl_wr_ptr",  128'(wr_ptr),   128'(vecs[r].exp_wp));
            check("tbl_wrapped", 128'(wrapped),  128'(vecs[r].exp_wrap));
            read_check(N_CH - 1, vecs[r].trig_at % DEPTH, "tbl_trig_read");
            oneshot_check(n, "tbl_oneshot");
        end

        tick();
        check("rd_valid_drop", 128'(rd_valid), 128'(0));
        pb_mode = 2'd0; pb_start = 1'b1; tick(); pb_start = 1'b0;
        check("pb_off_ignored", 128'(state), 128'(3));
        pb_mode = 2'd3; pb_start = 1'b1; tick(); pb_start = 1'b0;
        check("pb_rsvd_ignored", 128'(state), 128'(3));
        trig = 1'b1; force_freeze = 1'b1; tick(); trig = 1'b0; force_freeze = 1'b0;
        check("trig_frozen_ignored", 128'(trig_ptr), 128'(0));

        // Loop playback of a wrapped buffer, stopped after 40 entries.
        do_reset();
        capture(20, 3, -1, 40, 1'b0, n);
        pb_mode  = 2'd2;
        pb_start = 1'b1;
        tick();
        pb_start = 1'b0;
        tick();
        for (int i = 0; i < 40; i++) begin
            check("loop_entry", 128'({out_valid, out_data}), 128'(exp_word(n - DEPTH + (i % DEPTH))));
            if (i == 39) pb_stop = 1'b1;
            tick();
        end
        pb_stop = 1'b0;
        check("loop_stop_state", 128'(state), 128'(3));

        for (int it = 0; it < 6; it++) begin
            int ta, po, fa;
            ta = $urandom_range(0, 30);
            po = $urandom_range(0, 15);
            fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : -1;
            capture(ta, po, fa, 48, 1'b1, n);
            check("rnd_state",    128'(state),    128'(3));
            check("rnd_wr_ptr",   128'(wr_ptr),   128'(n % DEPTH));
            check("rnd_wrapped",  128'(wrapped),  128'(n >= DEPTH));
            check("rnd_trig_ptr", 128'(trig_ptr), 128'(m_tp));
            read_check($urandom_range(0, N_CH - 1), $urandom_range(0, DEPTH - 1), "rnd_read");
            read_check($urandom_range(0, N_CH - 1), $urandom_range(0, DEPTH - 1), "rnd_read");
            oneshot_check(n, "rnd_oneshot");
        end

        // Reset while in POST: controller clears, memory keeps its data.
        arm = 1'b1;
        tick();
        arm = 1'b0;
        post_cnt = AW'(10);
        for (int k = 0; k < 6; k++) begin
            drive_sample(k, 1'b0);
            trig = (k == 3);
            tick();
        end
        trig = 1'b0;
        check("pre_rst_post", 128'(state), 128'(2));
        for (int k = 0; k < 6; k++)
            for (int c = 0; c < N_CH; c++)
                mm[c][k] = hist[k][c];
        drive_sample(6, 1'b0);
        rd_en  = 1'b1;
        rst_hs = 1'b1;
        tick();
        rst_hs = 1'b0;
        rd_en  = 1'b0;
        check("post_rst_state",    128'(state),    128'(0));
        check("post_rst_wr_ptr",   128'(wr_ptr),   128'(0));
        check("post_rst_trig_ptr", 128'(trig_ptr), 128'(0));
        check("post_rst_wrapped",  128'(wrapped),  128'(0));
        check("post_rst_rd",       128'({rd_valid, rd_data}), 128'(0));
        check("post_rst_out",      128'({out_valid, out_data}), 128'(0));
        read_check(1, 2, "post_rst_read");
        read_check(N_CH - 1, 5, "post_rst_read");

        for (int i = 0; i < 3; i++) begin
            logic [N_CH*DATA_W-1:0] d;
            logic [N_CH-1:0]        v;
            d = {$urandom, $urandom};
            v = N_CH'($urandom);
            in_data  = d;
            in_valid = v;
            tick();
            check("live_pass", 128'({out_valid, out_data}), 128'({v, d}));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
